exe_stack_seq: RTL and testbench
================================

Name: exe_stack_seq

Overview:
- Multi-cycle control sequencer for the execute stage.
- Drives the execute ALU operand selects (ALU_A_SEL, ALU_B_SEL), MemInSel, stack-pointer update, memory handshake and PC load for stack instructions PUSH, POP, FUN (call) and RET, and for interrupt entry.
- Single-cycle opcodes pass straight through with combinational select decode.
- Asserts stall to freeze fetch/decode while a sequence runs.

Parameters:
- OP_PUSH, 5'h0F, PUSH opcode
- OP_POP, 5'h10, POP opcode
- OP_FUN, 5'h14, call opcode (save PC+4, jump)
- OP_RET, 5'h15, return opcode
- MEM_TIMEOUT, 16, max cycles waiting on mem_ready before abort

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- opcode  in  5  opcode of instruction in execute
- op_valid  in  1  instruction in execute is valid
- int_req  in  1  interrupt request, level
- mem_ready  in  1  memory completed current read/write
- ALU_A_SEL  out  2  00 RegData0, 01 SPout, 10 PC
- ALU_B_SEL  out  2  00 RegData1, 01 imm, 10 constant 4
- alu_sub  out  1  ALU subtracts B (SP decrement)
- MemInSel  out  1  memory address = SPout
- mem_data_sel  out  1  write data: 0 RegData1, 1 exeOut
- mem_wr  out  1  memory write request
- mem_rd  out  1  memory read request
- sp_we  out  1  write exeOut into SP
- reg_we  out  1  write memory read data to destination register (POP)
- pc_load  out  1  load PC
- pc_src  out  2  00 memory read data, 01 interrupt vector, 10 exeOut
- stall  out  1  hold upstream stages
- op_done  out  1  one-cycle pulse: instruction/interrupt entry retired
- int_ack  out  1  one-cycle pulse: interrupt taken
- mem_err  out  1  sticky, set on memory timeout

Behaviour:
- States: IDLE, WR, RD, SPI, SPD, JMP. Register kind ∈ {PUSH, POP, FUN, RET, INT}.
- Reset:
  - Forces IDLE, kind cleared, wait counter 0, mem_err 0.
  - All outputs 0 during and after reset until a new accept. Reset mid-sequence aborts with no further mem/sp/pc strobes.
- Outputs not listed for a state are 0.
- IDLE accept:
  - int_req has priority over op_valid: accepts kind=INT even if op_valid.
  - Otherwise, op_valid with a stack opcode is accepted. stall=1 combinationally in the accept cycle; the next state follows on the next edge.
- IDLE single-cycle op (op_valid, non-stack opcode):
  - ALU_A_SEL=00.
  - ALU_B_SEL=01 for opcodes 01,02,04,05,06,0C,0D,0E, else 00.
  - op_done=1 in the same cycle; stall=0.
- Sequences:
  - PUSH: WR→SPI→IDLE
  - POP: SPD→RD→IDLE
  - FUN: WR→SPI→JMP→IDLE
  - RET: SPD→RD→JMP→IDLE
  - INT: WR→SPI→JMP→IDLE
- WR:
  - MemInSel=1, mem_wr=1.
  - PUSH: A=01, B=10, mem_data_sel=0.
  - FUN/INT: A=10, B=10, mem_data_sel=1 (stores PC+4).
  - Holds until mem_ready, then advances.
- RD:
  - MemInSel=1, mem_rd=1; holds until mem_ready.
  - reg_we=1 in the mem_ready cycle for POP only.
  - RET captures read data into a return-address register in the mem_ready cycle.
- SPI: A=01, B=10, alu_sub=0, sp_we=1. One cycle; SP+=4.
- SPD: A=01, B=10, alu_sub=1, sp_we=1. One cycle; SP-=4.
- JMP: pc_load=1, one cycle.
  - FUN: pc_src=10, A=00, B=01 (target RegData0+imm).
  - RET: pc_src=00, using the captured return address.
  - INT: pc_src=01, int_ack=1.
- stall=1 in every non-IDLE state.
- op_done pulses in the final state's exit cycle: SPI for PUSH, RD@mem_ready for POP, JMP otherwise.
- Latency with mem_ready immediate: PUSH 2, POP 2, FUN 3, RET 3, INT 3 cycles after accept.
- Timeout: the wait counter resets on entry to WR/RD and increments each cycle without mem_ready. When it reaches MEM_TIMEOUT:
  - mem_err is set.
  - The FSM returns to IDLE with no sp_we/pc_load; op_done is not pulsed.
  - mem_err clears only on rst.
- int_req during a sequence is ignored until return to IDLE; it is sampled on the first IDLE cycle.
- mem_ready while not in WR/RD is ignored.

Test Plan:
- Reset mid-WR of PUSH (rst high 1 cycle) → next cycle state IDLE, stall=0, mem_wr=0, no sp_we pulse.
- opcode=01, op_valid=1 → same cycle ALU_B_SEL=01, ALU_A_SEL=00, op_done=1, stall=0; opcode=00 → ALU_B_SEL=00.
- PUSH, mem_ready delayed 3 cycles → WR held 4 cycles with MemInSel=1, mem_wr=1, mem_data_sel=0; then one SPI cycle (sp_we=1, alu_sub=0, A=01, B=10) with op_done=1.
- POP, mem_ready immediate → SPD (sp_we=1, alu_sub=1), then RD with reg_we=1 and op_done=1; stall high exactly 3 cycles including accept.
- int_req and op_valid (FUN) both high in IDLE → INT taken: WR with A=10, B=10, mem_data_sel=1; SPI; JMP with pc_src=01, int_ack=1; FUN re-presented afterwards completes with pc_src=10.
- RET with mem_ready never asserted, MEM_TIMEOUT=16 → after 16 RD cycles mem_err=1, IDLE, no pc_load/op_done; mem_err stays 1 until rst.

Source files
------------

// File: rtl/exe_stack_seq_if.sv
// Control bundle between the execute-stage stack sequencer and the datapath it steers.
// Master is the sequencer; slave is the datapath and memory side.
interface exe_stack_seq_if;
    logic [4:0] opcode;
    logic       op_valid;
    logic       int_req;
    logic       mem_ready;

    logic [1:0] ALU_A_SEL;
    logic [1:0] ALU_B_SEL;
    logic       alu_sub;
    logic       MemInSel;
    logic       mem_data_sel;
    logic       mem_wr;
    logic       mem_rd;
    logic       sp_we;
    logic       reg_we;
    logic       pc_load;
    logic [1:0] pc_src;
    logic       stall;
    logic       op_done;
    logic       int_ack;
    logic       mem_err;

    modport master (
        input  opcode, op_valid, int_req, mem_ready,
        output ALU_A_SEL, ALU_B_SEL, alu_sub, MemInSel, mem_data_sel,
               mem_wr, mem_rd, sp_we, reg_we, pc_load, pc_src,
               stall, op_done, int_ack, mem_err
    );

    modport slave (
        output opcode, op_valid, int_req, mem_ready,
        input  ALU_A_SEL, ALU_B_SEL, alu_sub, MemInSel, mem_data_sel,
               mem_wr, mem_rd, sp_we, reg_we, pc_load, pc_src,
               stall, op_done, int_ack, mem_err
    );
endinterface

// File: rtl/exe_stack_seq.sv
// Execute-stage sequencer for PUSH/POP/call/return and interrupt entry; other opcodes decode combinationally.
// Latency: single-cycle ops retire in the same cycle; PUSH/POP 2, FUN/RET/INT 3 cycles after accept.
// Backpressure: stall holds upstream for the whole sequence; WR/RD wait on mem_ready up to MEM_TIMEOUT cycles.
module exe_stack_seq #(
    parameter logic [4:0] OP_PUSH     = 5'h0F,
    parameter logic [4:0] OP_POP      = 5'h10,
    parameter logic [4:0] OP_FUN      = 5'h14,
    parameter logic [4:0] OP_RET      = 5'h15,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    exe_stack_seq_if.master bus
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_SPI, S_SPD, S_JMP} state_t;
    typedef enum logic [2:0] {K_NONE, K_PUSH, K_POP, K_FUN, K_RET, K_INT} kind_t;

    typedef struct packed {
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic       alu_sub;
        logic       mem_in_sel;
        logic       mem_data_sel;
        logic       mem_wr;
        logic       mem_rd;
        logic       sp_we;
        logic       pc_load;
        logic [1:0] pc_src;
        logic       int_ack;
        logic       op_done;
        logic       stall;
    } ctl_t;

    state_t        state_q, state_nx;
    kind_t         kind_q, kind_nx;
    logic [CW-1:0] wait_cnt;
    logic          mem_err_q;
    ctl_t          ctl_q;
    ctl_t          ctl_o;
    logic          reg_we_o;

    function automatic kind_t op_kind(input logic [4:0] op);
        kind_t k;
        k = K_NONE;
        if (op == OP_PUSH)     k = K_PUSH;
        else if (op == OP_POP) k = K_POP;
        else if (op == OP_FUN) k = K_FUN;
        else if (op == OP_RET) k = K_RET;
        return k;
    endfunction

    function automatic logic imm_op(input logic [4:0] op);
        logic r;
        case (op)
            5'h01, 5'h02, 5'h04, 5'h05, 5'h06, 5'h0C, 5'h0D, 5'h0E: r = 1'b1;
            default:                                                 r = 1'b0;
        endcase
        return r;
    endfunction

    // Control word held for a whole state; computed from the state being entered.
    function automatic ctl_t state_ctl(input state_t s, input kind_t k);
        ctl_t c;
        c = '0;
        case (s)
            S_WR: begin
                c.stall      = 1'b1;
                c.mem_in_sel = 1'b1;
                c.mem_wr     = 1'b1;
                c.b_sel      = 2'b10;
                if (k == K_PUSH) begin
                    c.a_sel        = 2'b01;
                    c.mem_data_sel = 1'b0;
                end else begin
                    c.a_sel        = 2'b10;
                    c.mem_data_sel = 1'b1;
                end
            end
            S_RD: begin
                c.stall      = 1'b1;
                c.mem_in_sel = 1'b1;
                c.mem_rd     = 1'b1;
            end
            S_SPI: begin
                c.stall   = 1'b1;
                c.a_sel   = 2'b01;
                c.b_sel   = 2'b10;
                c.sp_we   = 1'b1;
                c.op_done = (k == K_PUSH);
            end
            S_SPD: begin
                c.stall   = 1'b1;
                c.a_sel   = 2'b01;
                c.b_sel   = 2'b10;
                c.alu_sub = 1'b1;
                c.sp_we   = 1'b1;
            end
            S_JMP: begin
                c.stall   = 1'b1;
                c.pc_load = 1'b1;
                c.op_done = 1'b1;
                case (k)
                    K_FUN: begin
                        c.pc_src = 2'b10;
                        c.b_sel  = 2'b01;
                    end
                    K_INT: begin
                        c.pc_src  = 2'b01;
                        c.int_ack = 1'b1;
                    end
                    default: c.pc_src = 2'b00;
                endcase
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    logic in_idle, accept_int, accept_op, single_op, waiting, timeout;

    assign in_idle    = (state_q == S_IDLE);
    assign accept_int = in_idle && bus.int_req;
    assign accept_op  = in_idle && !bus.int_req && bus.op_valid && (op_kind(bus.opcode) != K_NONE);
    assign single_op  = in_idle && !bus.int_req && bus.op_valid && (op_kind(bus.opcode) == K_NONE);
    assign waiting    = (state_q == S_WR) || (state_q == S_RD);
    assign timeout    = waiting && !bus.mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_nx = state_q;
        kind_nx  = kind_q;
        case (state_q)
            S_IDLE: begin
                if (accept_int) begin
                    kind_nx  = K_INT;
                    state_nx = S_WR;
                end else if (accept_op) begin
                    kind_nx  = op_kind(bus.opcode);
                    state_nx = (kind_nx == K_POP || kind_nx == K_RET) ? S_SPD : S_WR;
                end
            end
            S_WR: begin
                if (bus.mem_ready)  state_nx = S_SPI;
                else if (timeout)   state_nx = S_IDLE;
            end
            // On RET the datapath's read-data register holds the return address
            // captured on this mem_ready strobe; pc_src=00 selects it in JMP.
            S_RD: begin
                if (bus.mem_ready)  state_nx = (kind_q == K_RET) ? S_JMP : S_IDLE;
                else if (timeout)   state_nx = S_IDLE;
            end
            S_SPI:   state_nx = (kind_q == K_PUSH) ? S_IDLE : S_JMP;
            S_SPD:   state_nx = S_RD;
            S_JMP:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (state_nx == S_IDLE) kind_nx = K_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            kind_q    <= K_NONE;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
            ctl_q     <= '0;
        end else begin
            state_q <= state_nx;
            kind_q  <= kind_nx;
            ctl_q   <= state_ctl(state_nx, kind_nx);
            if ((state_nx == S_WR || state_nx == S_RD) && state_nx != state_q)
                wait_cnt <= '0;
            else if (waiting && !bus.mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout)
                mem_err_q <= 1'b1;
        end
    end

    // IDLE decode and mem_ready-qualified strobes overlay the registered control word.
    always_comb begin
        ctl_o    = ctl_q;
        reg_we_o = 1'b0;
        if (single_op) begin
            ctl_o.b_sel   = imm_op(bus.opcode) ? 2'b01 : 2'b00;
            ctl_o.op_done = 1'b1;
        end
        if (accept_int || accept_op)
            ctl_o.stall = 1'b1;
        if (state_q == S_RD && bus.mem_ready && kind_q == K_POP) begin
            ctl_o.op_done = 1'b1;
            reg_we_o      = 1'b1;
        end
        if (rst) begin
            ctl_o    = '0;
            reg_we_o = 1'b0;
        end
    end

    assign bus.ALU_A_SEL    = ctl_o.a_sel;
    assign bus.ALU_B_SEL    = ctl_o.b_sel;
    assign bus.alu_sub      = ctl_o.alu_sub;
    assign bus.MemInSel     = ctl_o.mem_in_sel;
    assign bus.mem_data_sel = ctl_o.mem_data_sel;
    assign bus.mem_wr       = ctl_o.mem_wr;
    assign bus.mem_rd       = ctl_o.mem_rd;
    assign bus.sp_we        = ctl_o.sp_we;
    assign bus.reg_we       = reg_we_o;
    assign bus.pc_load      = ctl_o.pc_load;
    assign bus.pc_src       = ctl_o.pc_src;
    assign bus.stall        = ctl_o.stall;
    assign bus.op_done      = ctl_o.op_done;
    assign bus.int_ack      = ctl_o.int_ack;
    assign bus.mem_err      = mem_err_q && !rst;

endmodule

// File: tb/tb_exe_stack_seq.sv
// Directed bench: stimulus pushes per-cycle expected control words; a negedge monitor pops and compares.
module tb_exe_stack_seq;

    localparam logic [4:0] OPC_PUSH = 5'h0F;
    localparam logic [4:0] OPC_POP  = 5'h10;
    localparam logic [4:0] OPC_FUN  = 5'h14;
    localparam logic [4:0] OPC_RET  = 5'h15;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       sub;
        logic       mis;
        logic       mds;
        logic       wr;
        logic       rd;
        logic       spwe;
        logic       regwe;
        logic       pcl;
        logic [1:0] pcsrc;
        logic       stall;
        logic       done;
        logic       ack;
        logic       err;
    } exp_t;

    localparam exp_t E_ZERO     = '0;
    localparam exp_t E_STALL    = '{stall: 1'b1, default: '0};
    localparam exp_t E_SC_IMM   = '{b: 2'b01, done: 1'b1, default: '0};
    localparam exp_t E_SC_REG   = '{done: 1'b1, default: '0};
    localparam exp_t E_PUSH_WR  = '{a: 2'b01, b: 2'b10, mis: 1'b1, wr: 1'b1, stall: 1'b1, default: '0};
    localparam exp_t E_CALL_WR  = '{a: 2'b10, b: 2'b10, mis: 1'b1, mds: 1'b1, wr: 1'b1, stall: 1'b1, default: '0};
    localparam exp_t E_SPI      = '{a: 2'b01, b: 2'b10, spwe: 1'b1, stall: 1'b1, default: '0};
    localparam exp_t E_SPI_DONE = '{a: 2'b01, b: 2'b10, spwe: 1'b1, stall: 1'b1, done: 1'b1, default: '0};
    localparam exp_t E_SPD      = '{a: 2'b01, b: 2'b10, sub: 1'b1, spwe: 1'b1, stall: 1'b1, default: '0};
    localparam exp_t E_RD       = '{mis: 1'b1, rd: 1'b1, stall: 1'b1, default: '0};
    localparam exp_t E_RD_POP   = '{mis: 1'b1, rd: 1'b1, regwe: 1'b1, stall: 1'b1, done: 1'b1, default: '0};
    localparam exp_t E_JMP_FUN  = '{b: 2'b01, pcl: 1'b1, pcsrc: 2'b10, stall: 1'b1, done: 1'b1, default: '0};
    localparam exp_t E_JMP_RET  = '{pcl: 1'b1, pcsrc: 2'b00, stall: 1'b1, done: 1'b1, default: '0};
    localparam exp_t E_JMP_INT  = '{pcl: 1'b1, pcsrc: 2'b01, ack: 1'b1, stall: 1'b1, done: 1'b1, default: '0};

    logic clk;
    logic rst;
    exe_stack_seq_if bus();

    exe_stack_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  sticky_err = 1'b0;

    task automatic cyc(input string nm, input logic r, input logic [4:0] op, input logic v,
                       input logic ir, input logic mr, input exp_t e);
        @(posedge clk);
        #1;
        rst           = r;
        bus.opcode    = op;
        bus.op_valid  = v;
        bus.int_req   = ir;
        bus.mem_ready = mr;
        e.err = e.err | sticky_err;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    exp_t act;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            act = '{a: bus.ALU_A_SEL, b: bus.ALU_B_SEL, sub: bus.alu_sub, mis: bus.MemInSel,
                    mds: bus.mem_data_sel, wr: bus.mem_wr, rd: bus.mem_rd, spwe: bus.sp_we,
                    regwe: bus.reg_we, pcl: bus.pc_load, pcsrc: bus.pc_src, stall: bus.stall,
                    done: bus.op_done, ack: bus.int_ack, err: bus.mem_err};
            checks++;
            if (act != e) begin
                errors++;
                $display("FAIL %s got=%05h exp=%05h (a b sub mis mds wr rd spwe regwe pcl pcsrc stall done ack err)",
                         n, act, e);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.opcode    = 5'h00;
        bus.op_valid  = 1'b0;
        bus.int_req   = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset: outputs stay zero even with a valid op presented.
        cyc("reset0", 1, 5'h01, 1, 0, 0, E_ZERO);
        cyc("reset1", 1, OPC_PUSH, 1, 1, 1, E_ZERO);

        // Single-cycle decode.
        cyc("sc_01", 0, 5'h01, 1, 0, 0, E_SC_IMM);
        cyc("sc_00", 0, 5'h00, 1, 0, 0, E_SC_REG);
        cyc("sc_0C", 0, 5'h0C, 1, 0, 0, E_SC_IMM);
        cyc("sc_03", 0, 5'h03, 1, 0, 0, E_SC_REG);
        cyc("sc_inv", 0, 5'h01, 0, 0, 0, E_ZERO);

        // PUSH with mem_ready delayed three cycles.
        cyc("push_acc", 0, OPC_PUSH, 1, 0, 0, E_STALL);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("push_wr%0d", i), 0, OPC_PUSH, 0, 0, 0, E_PUSH_WR);
        cyc("push_wr3", 0, OPC_PUSH, 0, 0, 1, E_PUSH_WR);
        cyc("push_spi", 0, OPC_PUSH, 0, 0, 0, E_SPI_DONE);
        cyc("push_idle", 0, 5'h00, 0, 0, 0, E_ZERO);

        // POP with mem_ready held high throughout.
        cyc("pop_acc", 0, OPC_POP, 1, 0, 1, E_STALL);
        cyc("pop_spd", 0, OPC_POP, 0, 0, 1, E_SPD);
        cyc("pop_rd", 0, OPC_POP, 0, 0, 1, E_RD_POP);
        cyc("pop_idle", 0, OPC_POP, 0, 0, 1, E_ZERO);

        // Interrupt wins over a simultaneous call; the call then runs.
        cyc("int_acc", 0, OPC_FUN, 1, 1, 0, E_STALL);
        cyc("int_wr", 0, OPC_FUN, 1, 0, 1, E_CALL_WR);
        cyc("int_spi", 0, OPC_FUN, 1, 0, 0, E_SPI);
        cyc("int_jmp", 0, OPC_FUN, 1, 0, 0, E_JMP_INT);
        cyc("fun_acc", 0, OPC_FUN, 1, 0, 0, E_STALL);
        cyc("fun_wr", 0, OPC_FUN, 0, 0, 1, E_CALL_WR);
        cyc("fun_spi", 0, OPC_FUN, 0, 0, 0, E_SPI);
        cyc("fun_jmp", 0, OPC_FUN, 0, 0, 0, E_JMP_FUN);
        cyc("fun_idle", 0, 5'h00, 0, 0, 0, E_ZERO);

        // RET completes; int_req raised mid-sequence is taken on the first IDLE cycle.
        cyc("ret_acc", 0, OPC_RET, 1, 0, 0, E_STALL);
        cyc("ret_spd", 0, OPC_RET, 0, 1, 0, E_SPD);
        cyc("ret_rd", 0, OPC_RET, 0, 1, 1, E_RD);
        cyc("ret_jmp", 0, OPC_RET, 0, 1, 0, E_JMP_RET);
        cyc("ret_int_acc", 0, 5'h00, 0, 1, 0, E_STALL);
        cyc("ret_int_wr", 0, 5'h00, 0, 0, 1, E_CALL_WR);
        cyc("ret_int_spi", 0, 5'h00, 0, 0, 0, E_SPI);
        cyc("ret_int_jmp", 0, 5'h00, 0, 0, 0, E_JMP_INT);
        cyc("ret_int_idle", 0, 5'h00, 0, 0, 0, E_ZERO);

        // Reset in the middle of a PUSH write.
        cyc("rm_acc", 0, OPC_PUSH, 1, 0, 0, E_STALL);
        cyc("rm_wr0", 0, OPC_PUSH, 0, 0, 0, E_PUSH_WR);
        cyc("rm_wr1", 0, OPC_PUSH, 0, 0, 0, E_PUSH_WR);
        cyc("rm_rst", 1, OPC_PUSH, 0, 0, 1, E_ZERO);
        cyc("rm_post0", 0, 5'h00, 0, 0, 1, E_ZERO);
        cyc("rm_post1", 0, 5'h00, 0, 0, 0, E_ZERO);

        // RET with memory never answering: 16 RD cycles then abort with sticky error.
        cyc("to_acc", 0, OPC_RET, 1, 0, 0, E_STALL);
        cyc("to_spd", 0, OPC_RET, 0, 0, 0, E_SPD);
        for (int i = 0; i < 16; i++)
            cyc($sformatf("to_rd%0d", i), 0, OPC_RET, 0, 0, 0, E_RD);
        sticky_err = 1'b1;
        cyc("to_idle0", 0, 5'h00, 0, 0, 0, E_ZERO);
        cyc("to_idle1", 0, 5'h00, 0, 0, 1, E_ZERO);
        cyc("to_sc_05", 0, 5'h05, 1, 0, 0, E_SC_IMM);
        cyc("to_idle2", 0, 5'h00, 0, 0, 0, E_ZERO);
        sticky_err = 1'b0;
        cyc("to_rst", 1, 5'h00, 0, 0, 0, E_ZERO);
        cyc("to_clr", 0, 5'h00, 0, 0, 0, E_ZERO);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
